// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART transmitter: parity encodings,
// FSM state encoding and legal parameter ranges.
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    localparam int DATA_W_MIN     = 5;
    localparam int DATA_W_MAX     = 9;
    localparam int OVERSAMPLE_MIN = 4;
    localparam int OVERSAMPLE_MAX = 32;

    // Encoding 2'b11 is treated as "no parity", same as PAR_NONE.
    function automatic logic parity_enabled(input logic [1:0] mode);
        return (mode != PAR_NONE) && ((mode == PAR_EVEN) || (mode == PAR_ODD));
    endfunction

    function automatic bit cfg_legal(input int dw, input int os, input int depth);
        return (dw >= DATA_W_MIN) && (dw <= DATA_W_MAX) &&
               (os >= OVERSAMPLE_MIN) && (os <= OVERSAMPLE_MAX) &&
               (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous input FIFO for the UART transmitter; pointers carry one extra
// wrap bit so full and empty are distinguishable without a separate counter.
module uart_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic [DATA_W-1:0]        wdata,
    input  logic                     pop,
    output logic [DATA_W-1:0]        rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage needs no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

    assign level = wr_ptr - rd_ptr;
    assign full  = (level == (AW + 1)'(DEPTH));
    assign empty = (wr_ptr == rd_ptr);
    assign rdata = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/uart_tx_fifo.sv
// Parametrised UART transmitter with input FIFO, run-time parity selection
// and one or two stop bits; bit timing comes from the shared b_tick.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          b_tick,
    input  logic                          in_valid,
    input  logic [DATA_W-1:0]             in_data,
    output logic                          in_ready,
    input  logic [1:0]                    parity_mode,
    input  logic                          stop2,
    output logic                          tx,
    output logic                          tx_busy,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int BCW = $clog2(OVERSAMPLE);
    localparam int SCW = $clog2(2 * OVERSAMPLE);
    localparam int IW  = $clog2(DATA_W);

    localparam logic [BCW-1:0] B_LAST  = BCW'(OVERSAMPLE - 1);
    localparam logic [SCW-1:0] S_LAST1 = SCW'(OVERSAMPLE - 1);
    localparam logic [SCW-1:0] S_LAST2 = SCW'(2 * OVERSAMPLE - 1);
    localparam logic [IW-1:0]  I_LAST  = IW'(DATA_W - 1);

    if (!cfg_legal(DATA_W, OVERSAMPLE, FIFO_DEPTH)) begin : g_cfg_check
        $error("uart_tx_fifo: illegal DATA_W, OVERSAMPLE or FIFO_DEPTH");
    end

    tx_state_e         state_q, state_d;
    logic [BCW-1:0]    b_cnt_q, b_cnt_d;
    logic [SCW-1:0]    stop_cnt_q, stop_cnt_d;
    logic [IW-1:0]     bit_idx_q, bit_idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              par_en_q, par_en_d;
    logic              par_bit_q, par_bit_d;
    logic              stop2_q, stop2_d;
    logic              tx_q, tx_d;

    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_rdata;

    assign in_ready = !fifo_full;

    uart_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (in_valid && in_ready),
        .wdata  (in_data),
        .pop    (fifo_pop),
        .rdata  (fifo_rdata),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .level  (fifo_level)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            b_cnt_q    <= '0;
            stop_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            stop2_q    <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            b_cnt_q    <= b_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            stop2_q    <= stop2_d;
            tx_q       <= tx_d;
        end
    end

    // Parity and stop configuration are frozen at pop so mid-frame changes only affect the next word.
    always_comb begin
        state_d    = state_q;
        b_cnt_d    = b_cnt_q;
        stop_cnt_d = stop_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        stop2_d    = stop2_q;
        tx_d       = 1'b1;
        fifo_pop   = 1'b0;
        tx_done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    shift_d   = fifo_rdata;
                    par_en_d  = parity_enabled(parity_mode);
                    par_bit_d = (parity_mode == PAR_ODD) ? ~^fifo_rdata : ^fifo_rdata;
                    stop2_d   = stop2;
                    b_cnt_d   = '0;
                    state_d   = ST_START;
                end
            end
            ST_START: begin
                tx_d = 1'b0;
                if (b_tick) begin
                    if (b_cnt_q == B_LAST) begin
                        b_cnt_d   = '0;
                        bit_idx_d = '0;
                        state_d   = ST_DATA;
                    end else begin
                        b_cnt_d = b_cnt_q + 1'b1;
                    end
                end
            end
            ST_DATA: begin
                tx_d = shift_q[0];
                if (b_tick) begin
                    if (b_cnt_q == B_LAST) begin
                        b_cnt_d = '0;
                        shift_d = shift_q >> 1;
                        if (bit_idx_q == I_LAST) begin
                            stop_cnt_d = '0;
                            state_d    = par_en_q ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_idx_d = bit_idx_q + 1'b1;
                        end
                    end else begin
                        b_cnt_d = b_cnt_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                tx_d = par_bit_q;
                if (b_tick) begin
                    if (b_cnt_q == B_LAST) begin
                        b_cnt_d    = '0;
                        stop_cnt_d = '0;
                        state_d    = ST_STOP;
                    end else begin
                        b_cnt_d = b_cnt_q + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                tx_d = 1'b1;
                if (b_tick) begin
                    if (stop_cnt_q == (stop2_q ? S_LAST2 : S_LAST1)) begin
                        tx_done    = 1'b1;
                        stop_cnt_d = '0;
                        state_d    = ST_IDLE;
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign tx      = tx_q;
    assign tx_busy = (state_q != ST_IDLE);

endmodule
